// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program RAM read port, decode valid/ready handshake and redirect input.
// master = fetch unit side, slave = RAM/decode/branch side.
interface fetch_unit_if;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output mem_addr, mem_re, inst_valid, inst_data, inst_pc,
        input  mem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_re, inst_valid, inst_data, inst_pc,
        output mem_rdata, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC/issue logic, one in-flight RAM read and a {pc, inst} FIFO feeding decode.
// Macro FETCH_BYPASS_EN forwards a returning word straight to decode while the FIFO is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

    logic [31:0]                 pc_q, pc_d, inflight_pc_q, inflight_pc_d, issue_pc;
    logic                        inflight_q, inflight_d;
    logic [FIFO_DEPTH-1:0][31:0] fpc_q, fpc_d, fdata_q, fdata_d;
    logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        nonempty, bypass, valid, pop, push, fifo_pop, issue, room;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        nonempty = (count_q != '0);
`ifdef FETCH_BYPASS_EN
        bypass   = !nonempty && inflight_q && !bus.redirect_valid;
`else
        bypass   = 1'b0;
`endif
        valid          = nonempty || bypass;
        bus.inst_valid = valid;
        bus.inst_data  = bypass ? bus.mem_rdata : fdata_q[head_q];
        bus.inst_pc    = bypass ? inflight_pc_q : fpc_q[head_q];
        pop            = valid && bus.inst_ready;

        issue_pc     = bus.redirect_valid ? (bus.redirect_pc & ~32'h3) : pc_q;
        bus.mem_addr = {2'b00, issue_pc[31:2]};
        // Counting the in-flight read as occupied guarantees its slot exists when it returns.
        room         = (int'({1'b0, count_q}) + int'(inflight_q)) < FIFO_DEPTH;
        issue        = reset && (bus.redirect_valid || room || pop);
        bus.mem_re   = issue;

        push     = inflight_q && !bus.redirect_valid && !(bypass && pop);
        fifo_pop = pop && nonempty && !bus.redirect_valid;

        pc_d          = issue ? issue_pc + 32'd4 : pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? issue_pc : inflight_pc_q;

        fpc_d   = fpc_q;
        fdata_d = fdata_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                fpc_d[tail_q]   = inflight_pc_q;
                fdata_d[tail_q] = bus.mem_rdata;
                tail_d          = ptr_inc(tail_q);
            end
            if (fifo_pop) head_d = ptr_inc(head_q);
            if (push && !fifo_pop)      count_d = count_q + CW'(1);
            else if (fifo_pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= PC_INIT;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fpc_q         <= '0;
            fdata_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fpc_q         <= fpc_d;
            fdata_q       <= fdata_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk)
        if (reset && push) assert (count_q != CW'(FIFO_DEPTH));
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized ready/redirect traffic checked
// against an in-order PC stream model and a synchronous-read RAM model.
module tb_fetch_unit;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 1 : 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_pc;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Word-addressed contents: low words follow the 0x40 -> 0xA0 pattern, the rest are hashed.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a < 32'h100) return a + 32'h60;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always @(posedge clk) bus.mem_rdata <= ram_word(bus.mem_addr);

    task automatic test_reset();
        bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid); end
        checks++; if (bus.inst_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.inst_data); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.inst_pc); end
        checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re got=%b exp=0", bus.mem_re); end
        checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL reset_mem_addr got=%h exp=40", bus.mem_addr); end
    endtask

    task automatic test_startup();
        @(negedge clk);
        reset = 1'b1; bus.inst_ready = 1'b1;
        #1;
        checks++; if (bus.mem_re !== 1'b1) begin errors++; $display("FAIL start_mem_re got=%b exp=1", bus.mem_re); end
        checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL start_mem_addr got=%h exp=40", bus.mem_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL start_valid0 got=%b exp=0", bus.inst_valid); end
        for (int c = 1; c <= LAT + 2; c++) begin
            @(negedge clk); #1;
            checks++; if (bus.inst_valid !== (c >= LAT)) begin errors++; $display("FAIL start_valid c=%0d got=%b exp=%b", c, bus.inst_valid, c >= LAT); end
            if (c >= LAT) begin
                checks++; if (bus.inst_pc !== 32'h100 + 32'(4 * (c - LAT))) begin errors++; $display("FAIL start_pc got=%h exp=%h", bus.inst_pc, 32'h100 + 32'(4 * (c - LAT))); end
                checks++; if (bus.inst_data !== 32'hA0 + 32'(c - LAT)) begin errors++; $display("FAIL start_data got=%h exp=%h", bus.inst_data, 32'hA0 + 32'(c - LAT)); end
            end
        end
        exp_pc = 32'h10C;
    endtask

    task automatic test_stall();
        int pops = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); bus.inst_ready = 1'b1; #1;
            if (bus.inst_valid) begin
                checks++; if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL stall_pre_pc got=%h exp=%h", bus.inst_pc, exp_pc); end
                exp_pc += 4;
            end
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk); bus.inst_ready = 1'b0; #1;
            checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid s=%0d got=%b exp=1", s, bus.inst_valid); end
            checks++; if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL stall_head_pc s=%0d got=%h exp=%h", s, bus.inst_pc, exp_pc); end
            checks++; if (bus.inst_data !== ram_word({2'b00, exp_pc[31:2]})) begin errors++; $display("FAIL stall_head_data s=%0d got=%h exp=%h", s, bus.inst_data, ram_word({2'b00, exp_pc[31:2]})); end
            if (s >= 2) begin
                checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL stall_mem_re s=%0d got=%b exp=0", s, bus.mem_re); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); bus.inst_ready = 1'b1; #1;
            if (bus.inst_valid) begin
                pops++;
                checks++; if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL stall_resume_pc got=%h exp=%h", bus.inst_pc, exp_pc); end
                checks++; if (bus.inst_data !== ram_word({2'b00, exp_pc[31:2]})) begin errors++; $display("FAIL stall_resume_data got=%h exp=%h", bus.inst_data, ram_word({2'b00, exp_pc[31:2]})); end
                exp_pc += 4;
            end
        end
        checks++; if (pops != 8) begin errors++; $display("FAIL stall_resume_count got=%0d exp=8", pops); end
    endtask

    task automatic test_redirect_full();
        int pops = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.inst_ready = 1'b0;
        end
        @(negedge clk);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203;
        #1;
        checks++; if (bus.mem_addr !== 32'h80) begin errors++; $display("FAIL redir_mem_addr got=%h exp=80", bus.mem_addr); end
        checks++; if (bus.mem_re !== 1'b1) begin errors++; $display("FAIL redir_mem_re got=%b exp=1", bus.mem_re); end
        exp_pc = 32'h200;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); bus.redirect_valid = 1'b0; bus.inst_ready = 1'b1; #1;
            if (c == 1) begin
                checks++; if (bus.inst_valid !== BYP) begin errors++; $display("FAIL redir_next_valid got=%b exp=%b", bus.inst_valid, BYP); end
            end
            if (bus.inst_valid) begin
                pops++;
                checks++; if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL redir_pc got=%h exp=%h", bus.inst_pc, exp_pc); end
                checks++; if (bus.inst_data !== ram_word({2'b00, exp_pc[31:2]})) begin errors++; $display("FAIL redir_data got=%h exp=%h", bus.inst_data, ram_word({2'b00, exp_pc[31:2]})); end
                exp_pc += 4;
            end
        end
        checks++; if (pops != 9 - LAT) begin errors++; $display("FAIL redir_count got=%0d exp=%0d", pops, 9 - LAT); end
    endtask

    task automatic test_redirect_pop();
        int pops = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.inst_ready = 1'b1; #1;
            if (bus.inst_valid) begin
                checks++; if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL rpop_pre_pc got=%h exp=%h", bus.inst_pc, exp_pc); end
                exp_pc += 4;
            end
        end
        @(negedge clk);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300; bus.inst_ready = 1'b1;
        #1;
        exp_pc = 32'h300;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); bus.redirect_valid = 1'b0; #1;
            if (c == 1) begin
                checks++; if (bus.inst_valid !== BYP) begin errors++; $display("FAIL rpop_next_valid got=%b exp=%b", bus.inst_valid, BYP); end
            end
            if (bus.inst_valid) begin
                pops++;
                checks++; if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL rpop_pc got=%h exp=%h", bus.inst_pc, exp_pc); end
                checks++; if (bus.inst_data !== ram_word({2'b00, exp_pc[31:2]})) begin errors++; $display("FAIL rpop_data got=%h exp=%h", bus.inst_data, ram_word({2'b00, exp_pc[31:2]})); end
                exp_pc += 4;
            end
        end
        checks++; if (pops != 9 - LAT) begin errors++; $display("FAIL rpop_count got=%0d exp=%0d", pops, 9 - LAT); end
    endtask

    task automatic test_wrap();
        logic [31:0] seen [3];
        int pops = 0;
        @(negedge clk);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8; bus.inst_ready = 1'b1;
        #1;
        exp_pc = 32'hFFFF_FFF8;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); bus.redirect_valid = 1'b0; #1;
            if (bus.inst_valid) begin
                if (pops < 3) seen[pops] = bus.inst_pc;
                pops++;
                checks++; if (bus.inst_data !== ram_word({2'b00, exp_pc[31:2]})) begin errors++; $display("FAIL wrap_data got=%h exp=%h", bus.inst_data, ram_word({2'b00, exp_pc[31:2]})); end
                exp_pc += 4;
            end
        end
        checks++; if (pops < 3) begin errors++; $display("FAIL wrap_count got=%0d exp>=3", pops); end
        else begin
            checks++; if (seen[0] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_pc0 got=%h exp=fffffff8", seen[0]); end
            checks++; if (seen[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1 got=%h exp=fffffffc", seen[1]); end
            checks++; if (seen[2] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc2 got=%h exp=00000000", seen[2]); end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.inst_ready = 1'b1; #1;
            if (bus.inst_valid) begin
                checks++; if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL arst_pre_pc got=%h exp=%h", bus.inst_pc, exp_pc); end
                exp_pc += 4;
            end
        end
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", bus.inst_valid); end
        checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL arst_mem_re got=%b exp=0", bus.mem_re); end
        checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL arst_mem_addr got=%h exp=40", bus.mem_addr); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL arst_restart_addr got=%h exp=40", bus.mem_addr); end
        for (int c = 1; c <= LAT + 2; c++) begin
            @(negedge clk); #1;
            checks++; if (bus.inst_valid !== (c >= LAT)) begin errors++; $display("FAIL arst_valid c=%0d got=%b exp=%b", c, bus.inst_valid, c >= LAT); end
            if (c >= LAT) begin
                checks++; if (bus.inst_pc !== 32'h100 + 32'(4 * (c - LAT))) begin errors++; $display("FAIL arst_pc got=%h exp=%h", bus.inst_pc, 32'h100 + 32'(4 * (c - LAT))); end
                checks++; if (bus.inst_data !== 32'hA0 + 32'(c - LAT)) begin errors++; $display("FAIL arst_data got=%h exp=%h", bus.inst_data, 32'hA0 + 32'(c - LAT)); end
            end
        end
        exp_pc = 32'h10C;
    endtask

    task automatic test_random();
        bit prev_redir = 1'b0, prev_hold = 1'b0;
        logic [31:0] prev_pc = '0;
        int pops = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.inst_ready     = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            #1;
            if (prev_redir) begin
                checks++; if (bus.inst_valid !== (BYP && !bus.redirect_valid)) begin errors++; $display("FAIL rnd_post_redir_valid i=%0d got=%b exp=%b", i, bus.inst_valid, BYP && !bus.redirect_valid); end
            end
            if (prev_hold) begin
                checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== prev_pc) begin errors++; $display("FAIL rnd_hold i=%0d got=%b/%h exp=1/%h", i, bus.inst_valid, bus.inst_pc, prev_pc); end
            end
            if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                pops++;
                checks++; if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, bus.inst_pc, exp_pc); end
                checks++; if (bus.inst_data !== ram_word({2'b00, exp_pc[31:2]})) begin errors++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, bus.inst_data, ram_word({2'b00, exp_pc[31:2]})); end
                exp_pc += 4;
            end
            if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~32'h3;
            prev_redir = bus.redirect_valid;
            prev_hold  = bus.inst_valid && !bus.inst_ready && !bus.redirect_valid;
            prev_pc    = bus.inst_pc;
        end
        checks++; if (pops < 150) begin errors++; $display("FAIL rnd_throughput got=%0d exp>=150", pops); end
        @(negedge clk);
        bus.redirect_valid = 1'b0; bus.inst_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect_full();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that drives the word-addressed, synchronous-read program RAM and consumes its read data. It keeps the fetch PC and issues one read per cycle. It absorbs the RAM's one-cycle read latency, plus decode back-pressure, in a small instruction FIFO. It presents {pc, instruction} to decode over a valid/ready handshake and accepts branch/jump redirects that flush all in-flight work.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] ignored.
FIFO_DEPTH, 2, instruction FIFO entries; legal values 2..8; 2 is the minimum for 1 instr/cycle throughput.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
mem_addr  output  32  RAM word address = issue_pc[31:2], zero-extended; the RAM registers it every cycle
mem_re  output  1  high when the cycle's mem_addr is a real fetch request
mem_rdata  input  32  RAM read data, valid the cycle after the address was presented
inst_valid  output  1  FIFO head holds a valid instruction
inst_ready  input  1  decode accepts the head this cycle
inst_data  output  32  instruction word at FIFO head
inst_pc  output  32  byte PC of inst_data, bits [1:0] = 0
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new byte PC; bits [1:0] forced to 0

Behaviour:
- State: pc_q (next byte PC to fetch), inflight_q plus inflight_pc_q (request issued last cycle), FIFO of {pc, data} with head/tail pointers and count.
- Reset (async assert, sync release): pc_q = RESET_PC & ~3, inflight_q = 0, FIFO empty. Outputs: inst_valid = 0, inst_data = 0, inst_pc = 0, mem_re = 0. mem_addr = RESET_PC[31:2].
- pop = inst_valid & inst_ready.
- issue_pc = redirect_valid ? (redirect_pc & ~3) : pc_q. mem_addr always reflects issue_pc.
- mem_re = redirect_valid | ((count + inflight_q) < FIFO_DEPTH) | pop. A redirect always issues, because the flush frees every entry.
- On an issue edge: pc_q <= issue_pc + 4 (32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000); inflight_q <= 1; inflight_pc_q <= issue_pc. With no issue, pc_q holds and inflight_q <= 0.
- Response: in a cycle with inflight_q = 1 and no redirect, {inflight_pc_q, mem_rdata} is pushed at the edge. Space is guaranteed by the issue rule, so overflow cannot occur; a push into a full FIFO is an assertion error.
- Redirect cycle: FIFO cleared, the returning response (if any) discarded, pop ignored. inst_valid still shows the old head during this cycle, but decode must treat it as squashed. inst_valid = 0 in the next cycle.
- Simultaneous push and pop: count unchanged, both pointers advance modulo FIFO_DEPTH.
- Latency without bypass: request in cycle N, data pushed at the end of N+1, inst_valid in N+2. This holds both after reset release and after a redirect.
- Steady state with inst_ready = 1: one instruction per cycle, consecutive PCs +4.
- inst_ready low: the head and inst_valid hold stable; fetch stops once count + inflight reaches FIFO_DEPTH.
- The fetch unit never writes the RAM; the write port stays owned by the loader/LSU.

Optional Feature:
FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, inflight_q = 1 and there is no redirect, inst_valid = 1 and inst_data/inst_pc come combinationally from mem_rdata/inflight_pc_q.
  - If popped that cycle, nothing is pushed; otherwise the pair is pushed as normal.
  - Latency drops to request N -> inst_valid N+1.
- Undefined: the head is always registered from the FIFO; latency is N+2.

Test Plan:
- Reset release, RESET_PC=0x100, inst_ready=1, RAM words 0x40..0x44 = 0xA0..0xA4 -> inst_valid first rises 2 cycles after release; (pc, data) = (0x100,0xA0),(0x104,0xA1),(0x108,0xA2) on consecutive cycles.
- inst_ready=0 for 5 cycles mid-stream -> head stable; mem_re low once count+inflight=FIFO_DEPTH; no instruction lost or duplicated on resume.
- redirect_valid=1 with redirect_pc=0x203 while FIFO is full and a response is in flight -> mem_addr=0x80 that cycle; inst_valid=0 the next cycle; next delivered pc=0x200, then 0x204.
- redirect_valid and pop in the same cycle -> popped entry not re-delivered, no stale entry delivered; first output is the redirect target.
- redirect_pc=0xFFFF_FFF8, inst_ready=1 -> PCs delivered 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- reset asserted mid-stream with a response in flight -> inst_valid=0 immediately (async); after release, fetch restarts at RESET_PC with no stale data.
